// File: rtl/mem_array.sv
// mem_array: single-port synchronous RAM, 2**ADDR_W words of DATA_W bits.
// One rw bit picks write (1) or read (0) each cycle. Read data is captured
// in a register (1-cycle latency) and gated onto data_out by o_en.
// Reset clears the whole array as well as the read register.
//
// Ports:
//   clk      system clock, rising edge active
//   rst      asynchronous active-high reset
//   addr     word address for the current operation
//   rw       1 = write cycle, 0 = read cycle
//   data_in  write data
//   o_en     output enable; 0 forces data_out to zero
//   data_out read data (rd_q gated by o_en)
module mem_array #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic [DATA_W-1:0] data_in,
  input  logic              o_en,
  output logic [DATA_W-1:0] data_out
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] rd_d;

  // Storage is built from async-clear flops so reset empties every word,
  // which is what lets unwritten locations read back as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (rw) begin
      mem_q[addr] <= data_in;
    end
  end

  // Read register holds through write cycles and updates on every read,
  // independent of o_en.
  always_comb begin
    rd_d = rd_q;
    if (!rw) begin
      rd_d = mem_q[addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign data_out = o_en ? rd_q : '0;

endmodule

// File: tb/tb_mem_array.sv
module tb_mem_array;

  localparam int AW    = 3;
  localparam int DW    = 5;
  localparam int DEPTH = 2 ** AW;

  logic          clk;
  logic          rst;
  logic [AW-1:0] addr;
  logic          rw;
  logic [DW-1:0] data_in;
  logic          o_en;
  logic [DW-1:0] data_out;

  int errors;
  int checks;

  // Reference model: plain array of words plus the last value read.
  int ref_mem [DEPTH];
  int ref_rd;

  mem_array #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .rw       (rw),
    .data_in  (data_in),
    .o_en     (o_en),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int expected_out();
    return o_en ? ref_rd : 0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 0;
    ref_rd = 0;
  endtask

  // One clocked operation: drive at negedge, update model at posedge,
  // sample 1 ns later.
  task automatic cyc(input logic w, input int a, input int d, input logic oe,
                     input string tag);
    @(negedge clk);
    rw      = w;
    addr    = AW'(a);
    data_in = DW'(d);
    o_en    = oe;
    @(posedge clk);
    if (w) ref_mem[a] = d;
    else   ref_rd     = ref_mem[a];
    #1;
    chk(tag, int'(data_out), expected_out());
  endtask

  // Combinational o_en change, no clock edge in between.
  task automatic set_oen(input logic v, input string tag);
    o_en = v;
    #1;
    chk(tag, int'(data_out), expected_out());
  endtask

  // Assert rst between edges with o_en high, hold it across one clock edge
  // carrying a write, then release with a harmless read of address 0.
  task automatic mid_reset(input int wa, input int wd);
    o_en = 1'b1;
    rst  = 1'b1;
    #1;
    chk("rst_immediate", int'(data_out), 0);
    model_clear();
    @(negedge clk);
    rw      = 1'b1;
    addr    = AW'(wa);
    data_in = DW'(wd);
    @(posedge clk);
    #1;
    chk("rst_held", int'(data_out), 0);
    @(negedge clk);
    rst  = 1'b0;
    rw   = 1'b0;
    addr = '0;
    ref_rd = ref_mem[0];
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, i, 0, 1'b1, tag);
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst     = 1'b0;
    rw      = 1'b0;
    addr    = '0;
    data_in = '0;
    o_en    = 1'b1;
    model_clear();

    #2 rst = 1'b1;
    #1;
    chk("reset_out", int'(data_out), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    read_all("post_reset_read");

    for (int i = 0; i < DEPTH; i++) cyc(1'b1, i, i, 1'b1, "fill_write");
    read_all("fill_read");
    cyc(1'b0, 7, 0, 1'b1, "final_read7");
    chk("final_read7_value", int'(data_out), 7);

    cyc(1'b0, 5, 0, 1'b1, "read5");
    set_oen(1'b0, "oen_low");
    chk("oen_low_zero", int'(data_out), 0);
    set_oen(1'b1, "oen_high");
    chk("oen_high_five", int'(data_out), 5);
    cyc(1'b0, 3, 0, 1'b0, "read3_oen_low");
    set_oen(1'b1, "read3_raise_oen");
    chk("read3_value", int'(data_out), 3);

    cyc(1'b1, 2, 31, 1'b1, "overwrite2");
    cyc(1'b0, 2, 0, 1'b1, "wtr_read2");
    chk("wtr_value", int'(data_out), 31);
    read_all("after_overwrite");

    cyc(1'b0, 4, 0, 1'b1, "read4");
    for (int k = 0; k < 4; k++) cyc(1'b1, 6, 10 + k, 1'b1, "write_hold4");
    chk("hold4_value", int'(data_out), 4);
    cyc(1'b0, 6, 0, 1'b1, "read6");

    cyc(1'b0, 6, 0, 1'b1, "pre_rst_read");
    mid_reset(0, 0);
    read_all("rst_mid_read");

    for (int i = 0; i < 4; i++) cyc(1'b1, i, 20 + i, 1'b1, "burst_write");
    mid_reset(1, 9);
    read_all("rst_burst_read");
    cyc(1'b0, 1, 0, 1'b1, "coincide_write");
    chk("coincide_value", int'(data_out), 0);

    for (int n = 0; n < 400; n++) begin
      cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
          int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), "rand_op");
      if ($urandom_range(0, 7) == 0) set_oen(~o_en, "rand_oen");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
